// File: rtl/bcd_pkg.sv
//------------------------------------------------------------------------------
// Module  : bcd_pkg
// Purpose : Shared constants for the sequential binary-to-BCD converter.
//           This file provides the FSM state encoding, the digit-adjust
//           threshold and addend, the saturation value and the accumulator
//           digit count.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Double-dabble digit correction: digits >= 5 get +3 before each shift
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Display value used when the result does not fit in four digits
  localparam logic [15:0] BCD_SAT_VAL = 16'h9999;

  // Accumulator holds five digits so 65535 converts without loss
  localparam int BCD_DIGITS = 5;
  localparam int ACC_W      = 4 * BCD_DIGITS;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
//------------------------------------------------------------------------------
// Module  : bcd_digit_adj
// Purpose : Combinational double-dabble correction cell. If the input digit
//           is 5 or more, the cell adds 3 to it. Otherwise the digit passes
//           through unchanged.
// Ports   : digit_in  [3:0]  BCD digit before adjustment
//           digit_out [3:0]  adjusted digit
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // A legal digit (0..9) plus 3 stays within 4 bits (max 12).
  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD)
                                                  : digit_in;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
//------------------------------------------------------------------------------
// Module  : bin2bcd_seq
// Purpose : Sequential shift-add-3 (double-dabble) binary to packed BCD
//           converter. The converter performs one iteration per clock. The
//           result registers hold their value between conversions, so the
//           display driver fed by bcd never sees intermediate values.
// Ports   : clk          system clock, rising edge
//           rst          synchronous active-high reset
//           start        conversion request, sampled in IDLE only
//           bin  [BIN_W] unsigned binary input, captured on accepted start
//           bcd  [15:0]  {thousands, hundreds, tens, ones}, registered
//           busy         high while iterating (SHIFT state)
//           done         one-cycle pulse when bcd first shows a new result
//           ovf          registered; last converted value exceeded 9999
// Config  : BCD_SAT_EN - when defined, an overflowing result loads bcd with
//           16'h9999 instead of the value mod 10000.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 16,  // 4..16
  parameter int CNT_W = 5    // 2**CNT_W > BIN_W
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [15:0]      bcd,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

`ifdef BCD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [1:0]             r_state;
  logic [ACC_W-1:0]       r_acc;
  logic [BIN_W-1:0]       r_bin;
  logic [CNT_W-1:0]       r_cnt;

  logic [ACC_W-1:0]       w_adj;
  logic [ACC_W+BIN_W-1:0] w_shift;
  logic [ACC_W-1:0]       w_acc_next;
  logic [BIN_W-1:0]       w_bin_next;
  logic                   w_last;
  logic                   w_ovf_next;
  logic [15:0]            w_bcd_next;

  // All accumulator digits are corrected in parallel before the shift.
  generate
    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
      bcd_digit_adj u_adj (
        .digit_in  (r_acc[4*i +: 4]),
        .digit_out (w_adj[4*i +: 4])
      );
    end
  endgenerate

  // {accumulator, binary} shifts left as one register. The binary MSB
  // enters the ones digit.
  assign w_shift    = {w_adj, r_bin} << 1;
  assign w_acc_next = w_shift[ACC_W+BIN_W-1:BIN_W];
  assign w_bin_next = w_shift[BIN_W-1:0];
  assign w_last     = (r_cnt == CNT_W'(BIN_W - 1));

  // Results come from the post-shift accumulator of the final iteration.
  assign w_ovf_next = |w_acc_next[ACC_W-1:16];
  assign w_bcd_next = (SAT_EN && w_ovf_next) ? BCD_SAT_VAL : w_acc_next[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      bcd     <= 16'h0000;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_acc_next;
          r_bin <= w_bin_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            bcd     <= w_bcd_next;
            ovf     <= w_ovf_next;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode directly from the registered state.
  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential shift-add-3 (double-dabble) converter that turns a 16-bit binary value into 4 packed BCD digits.
- Output drives the 16-bit `num` input of the 4-digit seven-segment display driver directly, so CPU values appear in decimal.
- Sits between the CPU debug/value mux and the display driver.
- Holds the last result stable between conversions so the display never flickers mid-conversion.

Parameters:
- BIN_W, 16, binary input width; supported range 4..16.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > BIN_W.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion of `bin`; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value; captured on the accepted start edge.
- bcd  output  16  packed BCD {thousands, hundreds, tens, ones}; registered.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse in the cycle `bcd` first shows a new result.
- ovf  output  1  registered; high if the last converted value exceeds 9999.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. Reset values: bcd=16'h0000, busy=0, done=0, ovf=0, state=IDLE, internal shift register and counter cleared.
- Internal state: 20-bit BCD accumulator (5 digits), BIN_W-bit binary shift register, CNT_W-bit counter.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a posedge: load binary reg <= bin, accumulator <= 0, counter <= 0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one iteration per cycle:
  - Each accumulator nibble >= 5 gets +3 (all 5 digits adjusted in parallel, combinationally).
  - Then shift {accumulator, binary reg} left by 1.
  - counter++.
  - After exactly BIN_W iterations, go to DONE.
- Output update on the SHIFT->DONE edge: bcd <= accumulator[15:0] (or the saturated value, see Optional Feature); ovf <= (accumulator[19:16] != 0).
- DONE: done=1 for exactly this one cycle, busy=0, then unconditionally return to IDLE.
- Latency: start accepted at edge N. busy is high in cycles N+1..N+BIN_W. done and the new bcd appear in cycle N+BIN_W+1 (N+17 for default BIN_W). Minimum start-to-start interval is BIN_W+2 cycles.
- Start outside IDLE: ignored in SHIFT and DONE; it is not queued. A caller holding start high gets back-to-back conversions, each re-sampling `bin`.
- bin changing during SHIFT: no effect on the conversion in progress.
- bcd and ovf hold their values through IDLE and SHIFT; they change only on the SHIFT->DONE edge or on reset.
- Reset mid-conversion: aborts immediately; no done pulse; outputs return to their reset values.
- rst has priority over start in the same cycle.
- Boundary values: bin=0 gives bcd=0000, ovf=0. bin=9999 gives bcd=9999, ovf=0. Any bin >= 10000 sets ovf=1.

Optional Feature:
- Macro: BCD_SAT_EN.
- Defined: when ovf=1, bcd is loaded with 16'h9999, so the display pins at 9999.
- Undefined: bcd is loaded with the low 4 digits, i.e. value mod 10000 (e.g. 12345 -> 2345).
- ovf is driven identically in both builds.

Decomposition:
- Package bcd_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - BCD_ADJ_THRESH=4'd5 and BCD_ADJ_ADD=4'd3.
  - BCD_SAT_VAL=16'h9999 and BCD_DIGITS=5.
- One sub-module: bcd_digit_adj, a combinational 4-bit "if >=5 add 3" cell instantiated 5 times across the accumulator.
- Everything else (FSM, shift registers, counter, output registers) lives in bin2bcd_seq.

Test Plan:
- Reset, then start with bin=16'd1234 -> busy high for 16 cycles; done pulses in cycle 17; bcd=16'h1234, ovf=0.
- bin=0, then bin=9999 -> bcd=16'h0000 then 16'h9999, ovf=0 both times; exactly one done pulse per conversion.
- bin=10000 and bin=65535 -> ovf=1. Without BCD_SAT_EN: bcd=16'h0000 and 16'h5535. With BCD_SAT_EN: bcd=16'h9999 for both.
- Start bin=42, then pulse start with bin=777 during SHIFT cycle 5 -> result bcd=16'h0042; second start ignored; no extra done.
- Complete a conversion of 1234, then start 5678 and assert rst in SHIFT cycle 8 -> busy=0 and bcd=0 on the next cycle; no done pulse.
- start held high continuously with bin=321 -> done pulses every 18 cycles; bcd stays 16'h0321 between pulses.
